// File: rtl/bnn_layer_scheduler.sv
// Layer sequencer for the shared conv+pool engine: walks the weight banks,
// ping-pongs the feature-map buffers and guards each layer with a timeout.
module bnn_layer_scheduler #(
   parameter int NUM_LAYERS = 3,
   parameter int LAYER_W    = $clog2(NUM_LAYERS) > 0 ? $clog2(NUM_LAYERS) : 1,
   parameter int TIMEOUT    = 4096,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic               eng_data_in_ready,
   input  logic               eng_data_out_ready,
   output logic [LAYER_W-1:0] wbank_sel,
   output logic               buf_rd_sel,
   output logic               buf_wr_en,
   output logic               busy,
   output logic               done,
   output logic               timeout_err,
   output logic [CNT_W-1:0]   layer_cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_CAP,
      S_ADV,
      S_FIN,
      S_ERR
   } state_t;

   localparam logic [CNT_W-1:0]   CNT_MAX = '1;
   localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [LAYER_W-1:0] LAST    = LAYER_W'(NUM_LAYERS - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   // Saturating increment: a stuck engine must never wrap the count
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         cnt               <= '0;
         eng_data_in_ready <= 1'b0;
         wbank_sel         <= '0;
         buf_rd_sel        <= 1'b0;
         buf_wr_en         <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         timeout_err       <= 1'b0;
         layer_cycles      <= '0;
      end else begin
         buf_wr_en <= 1'b0;
         done      <= 1'b0;
         if (abort) begin
            state             <= S_IDLE;
            eng_data_in_ready <= 1'b0;
            busy              <= 1'b0;
            wbank_sel         <= '0;
            buf_rd_sel        <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE, S_ERR: begin
                  if (start) begin
                     state       <= S_ARM;
                     busy        <= 1'b1;
                     wbank_sel   <= '0;
                     buf_rd_sel  <= 1'b0;
                     timeout_err <= 1'b0;
                  end
               end
               S_ARM: begin
                  cnt               <= '0;
                  state             <= S_RUN;
                  eng_data_in_ready <= 1'b1;
               end
               S_RUN: begin
                  cnt <= cnt_inc;
                  if (eng_data_out_ready) begin
                     layer_cycles <= cnt_inc;
                     buf_wr_en    <= 1'b1;
                     state        <= S_CAP;
                  end else if (cnt == TO_LAST) begin
                     timeout_err       <= 1'b1;
                     eng_data_in_ready <= 1'b0;
                     busy              <= 1'b0;
                     state             <= S_ERR;
                  end
               end
               S_CAP: begin
                  eng_data_in_ready <= 1'b0;
                  buf_rd_sel        <= ~buf_rd_sel;
                  state             <= S_ADV;
               end
               S_ADV: begin
                  if (wbank_sel == LAST) begin
                     done  <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     wbank_sel <= wbank_sel + LAYER_W'(1);
                     state     <= S_ARM;
                  end
               end
               S_FIN: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  eng_data_in_ready <= 1'b0;
                  busy              <= 1'b0;
                  state             <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bnn_layer_scheduler.sv
// Directed bench for bnn_layer_scheduler with a behavioural engine and a
// capture scoreboard; a second single-layer instance covers NUM_LAYERS=1.
module tb_bnn_layer_scheduler;

   typedef struct {
      logic [1:0]  wb;
      logic        rd;
      logic [15:0] lc;
   } cap_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        start1 = 1'b0;
   logic        ordy, ordy1;
   logic        in0, wr0, rd0, busy0, done0, terr0;
   logic [1:0]  wb0;
   logic [15:0] lc0;
   logic        in1, wr1, rd1, busy1, done1, terr1;
   logic [0:0]  wb1;
   logic [15:0] lc1;

   logic eng_en = 1'b1;
   logic glitch = 1'b0;
   logic m0 = 1'b0;
   logic m1 = 1'b0;
   int   ecnt0 = 0;
   int   ecnt1 = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   cap_t sb[$];

   always #5 clk = ~clk;

   bnn_layer_scheduler #(.NUM_LAYERS(3), .TIMEOUT(32), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .eng_data_in_ready(in0), .eng_data_out_ready(ordy),
      .wbank_sel(wb0), .buf_rd_sel(rd0), .buf_wr_en(wr0),
      .busy(busy0), .done(done0), .timeout_err(terr0),
      .layer_cycles(lc0)
   );

   bnn_layer_scheduler #(.NUM_LAYERS(1), .TIMEOUT(32), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
      .eng_data_in_ready(in1), .eng_data_out_ready(ordy1),
      .wbank_sel(wb1), .buf_rd_sel(rd1), .buf_wr_en(wr1),
      .busy(busy1), .done(done1), .timeout_err(terr1),
      .layer_cycles(lc1)
   );

   // Engine: reports done on the 11th cycle of in_ready high
   always @(posedge clk) begin
      #1;
      ecnt0 = in0 ? ecnt0 + 1 : 0;
      ecnt1 = in1 ? ecnt1 + 1 : 0;
      m0 = eng_en && (ecnt0 == 11);
      m1 = (ecnt1 == 11);
   end
   assign ordy  = m0 | glitch;
   assign ordy1 = m1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && wr0) begin
         if (sb.size() == 0) begin
            chk("unexpected_wr_en", 1, 0);
         end else begin
            cap_t e;
            e = sb.pop_front();
            chk("cap_wbank", 32'(wb0), 32'(e.wb));
            chk("cap_rd_sel", 32'(rd0), 32'(e.rd));
            chk("cap_layer_cycles", 32'(lc0), 32'(e.lc));
         end
      end
   end

   task automatic push_layers(input int n);
      for (int l = 0; l < n; l++) begin
         cap_t e;
         e.wb = l[1:0];
         e.rd = l[0];
         e.lc = 16'd11;
         sb.push_back(e);
      end
   endtask

   task automatic run_pass(input bit disturb, output int dt, output int nd);
      push_layers(3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dt = -1;
      nd = 0;
      for (int t = 1; t <= 60; t++) begin
         if (t == 1) chk("terr_cleared", 32'(terr0), 0);
         if (t == 2) chk("in_ready_lat", 32'(in0), 1);
         if (disturb) begin
            if (t == 1) glitch = 1'b1;
            if (t == 2) glitch = 1'b0;
            if (t == 5) start = 1'b1;
            if (t == 6) start = 1'b0;
         end
         if (done0) begin
            nd++;
            if (dt < 0) dt = t;
         end
         @(negedge clk);
      end
   endtask

   task automatic quiet(input int n, output int nd);
      nd = 0;
      for (int t = 0; t < n; t++) begin
         if (done0) nd++;
         @(negedge clk);
      end
   endtask

   initial begin
      int dt, nd, t, nwr, wt;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_in_ready", 32'(in0), 0);
      chk("rst_wbank", 32'(wb0), 0);
      chk("rst_rd_sel", 32'(rd0), 0);
      chk("rst_done", 32'(done0), 0);
      chk("rst_lc", 32'(lc0), 0);
      rst = 1'b0;
      @(negedge clk);

      // nominal pass
      run_pass(1'b0, dt, nd);
      chk("nom_done_t", dt, 43);
      chk("nom_done_n", nd, 1);
      chk("nom_rd_sel", 32'(rd0), 1);
      chk("nom_wbank", 32'(wb0), 2);
      chk("nom_busy", 32'(busy0), 0);
      chk("nom_sb_empty", sb.size(), 0);

      // idle glitch, then ARM glitch plus start while busy
      glitch = 1'b1;
      @(negedge clk);
      glitch = 1'b0;
      @(negedge clk);
      chk("idle_glitch_busy", 32'(busy0), 0);
      run_pass(1'b1, dt, nd);
      chk("dist_done_t", dt, 43);
      chk("dist_done_n", nd, 1);
      chk("dist_sb_empty", sb.size(), 0);

      // engine never responds
      eng_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 1;
      while (!terr0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("to_time", t, 34);
      chk("to_busy", 32'(busy0), 0);
      chk("to_in_ready", 32'(in0), 0);
      eng_en = 1'b1;
      run_pass(1'b0, dt, nd);
      chk("to_rerun_done_t", dt, 43);
      chk("to_rerun_wbank", 32'(wb0), 2);

      // async reset during layer 1 RUN
      push_layers(1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      chk("mid_wbank", 32'(wb0), 1);
      chk("mid_in_ready", 32'(in0), 1);
      #2 rst = 1'b1;
      #1;
      chk("rstm_outs", 32'({in0, wb0, rd0, wr0, busy0, done0, terr0}), 0);
      chk("rstm_lc", 32'(lc0), 0);
      @(negedge clk);
      rst = 1'b0;
      quiet(20, nd);
      chk("rstm_no_done", nd, 0);
      chk("rstm_busy", 32'(busy0), 0);
      chk("rstm_sb_empty", sb.size(), 0);

      // abort during layer 1 CAPTURE
      push_layers(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (26) @(negedge clk);
      chk("abt_wr_en", 32'(wr0), 1);
      chk("abt_wbank_cap", 32'(wb0), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abt_busy", 32'(busy0), 0);
      chk("abt_wbank", 32'(wb0), 0);
      chk("abt_rd_sel", 32'(rd0), 0);
      chk("abt_in_ready", 32'(in0), 0);
      quiet(20, nd);
      chk("abt_no_done", nd, 0);
      chk("abt_sb_empty", sb.size(), 0);
      run_pass(1'b0, dt, nd);
      chk("abt_rerun_done_t", dt, 43);
      chk("abt_rerun_done_n", nd, 1);

      // single-layer instance
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      dt = -1;
      nwr = 0;
      wt = -1;
      for (int k = 1; k <= 30; k++) begin
         if (wr1) begin
            nwr++;
            wt = k;
         end
         if (done1 && dt < 0) dt = k;
         @(negedge clk);
      end
      chk("nl1_wr_n", nwr, 1);
      chk("nl1_wr_t", wt, 13);
      chk("nl1_done_t", dt, 15);
      chk("nl1_rd_sel", 32'(rd1), 1);
      chk("nl1_lc", 32'(lc1), 11);
      chk("nl1_busy", 32'(busy1), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
